ps2_player_cmd: RTL and testbench

- Sits directly downstream of the PS/2 keyboard receiver. Consumes its 16-bit held-key word: [7:0] = tank key, [15:8] = train key, 0x00 = released.
- Converts held keys into per-player game commands: latched direction, move pulses with typematic auto-repeat, rate-limited fire pulses, and a start pulse.
- Outputs feed the game/bot control logic in the clk domain.

---
 rtl/ps2_keys_pkg.sv | 34 +++
 rtl/ps2_key_ctrl.sv | 124 ++++++++++++
 rtl/ps2_player_cmd.sv | 98 +++++++++
 tb/tb_ps2_player_cmd.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keys_pkg.sv
// PS/2 set-2 make codes for the two-player keyboard layout, direction
// encodings shared by both players, and the per-player command state type.
package ps2_keys_pkg;

  // Tank keys
  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_Q     = 8'h15;
  localparam logic [7:0] KEY_ENTER = 8'h5A;

  // Train keys
  localparam logic [7:0] KEY_I     = 8'h43;
  localparam logic [7:0] KEY_K     = 8'h42;
  localparam logic [7:0] KEY_J     = 8'h3B;
  localparam logic [7:0] KEY_L     = 8'h4B;
  localparam logic [7:0] KEY_U     = 8'h3C;

  // Break prefix; the receiver consumes it, kept for reference only
  localparam logic [7:0] KEY_BREAK = 8'hF0;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_FIRE = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/ps2_key_ctrl.sv
// One player's command FSM: latched direction, move pulses with typematic
// auto-repeat, and cooldown-limited fire pulses. All outputs are registered.
module ps2_key_ctrl
  import ps2_keys_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000,
  parameter int unsigned COOLDOWN     = 12_500_000,
  parameter int unsigned CNT_W        = 25,
  parameter logic [7:0]  KEY_UP       = KEY_W,
  parameter logic [7:0]  KEY_DOWN     = KEY_S,
  parameter logic [7:0]  KEY_LEFT     = KEY_A,
  parameter logic [7:0]  KEY_RIGHT    = KEY_D,
  parameter logic [7:0]  KEY_FIRE     = KEY_Q
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] key_cur,
  input  logic       key_chg,
  output logic [1:0] dir,
  output logic       move,
  output logic       held,
  output logic       fire
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LD_DELAY = CNT_W'(REPEAT_DELAY - 32'd1);
  localparam logic [CNT_W-1:0] LD_RATE  = CNT_W'(REPEAT_RATE - 32'd1);
  localparam logic [CNT_W-1:0] LD_COOL  = CNT_W'(COOLDOWN - 32'd1);

  // Returns {is_direction, direction code}
  function automatic logic [2:0] dir_decode(input logic [7:0] k);
    logic [2:0] r;
    case (k)
      KEY_UP:    r = {1'b1, DIR_UP};
      KEY_DOWN:  r = {1'b1, DIR_DOWN};
      KEY_LEFT:  r = {1'b1, DIR_LEFT};
      KEY_RIGHT: r = {1'b1, DIR_RIGHT};
      default:   r = 3'b000;
    endcase
    return r;
  endfunction

  ctrl_state_e      state_r, state_s;
  logic [1:0]       dir_r, dir_s;
  logic [CNT_W-1:0] rpt_r, rpt_s;
  logic [CNT_W-1:0] cd_r, cd_s;
  logic             move_r, move_s;
  logic             fire_r, fire_s;
  logic             held_r;
  logic [2:0]       dec_s;

  // Next-state, counter and pulse decisions for this player
  always_comb begin
    dec_s   = dir_decode(key_cur);
    state_s = state_r;
    dir_s   = dir_r;
    rpt_s   = rpt_r;
    move_s  = 1'b0;
    fire_s  = 1'b0;
    if (cd_r != CNT_ZERO) begin
      cd_s = cd_r - CNT_ONE;
    end else begin
      cd_s = CNT_ZERO;
    end

    if (key_chg) begin
      if (dec_s[2]) begin
        state_s = ST_MOVE;
        dir_s   = dec_s[1:0];
        move_s  = 1'b1;
        rpt_s   = LD_DELAY;
      end else if (key_cur == KEY_FIRE) begin
        state_s = ST_FIRE;
        // A press during cooldown is dropped rather than queued
        if (cd_r == CNT_ZERO) begin
          fire_s = 1'b1;
          cd_s   = LD_COOL;
        end else begin
          fire_s = 1'b0;
        end
      end else begin
        state_s = ST_IDLE;
      end
    end else if (state_r == ST_MOVE) begin
      if (rpt_r == CNT_ZERO) begin
        move_s = 1'b1;
        rpt_s  = LD_RATE;
      end else begin
        rpt_s  = rpt_r - CNT_ONE;
      end
    end else begin
      rpt_s = rpt_r;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      dir_r   <= DIR_UP;
      rpt_r   <= CNT_ZERO;
      cd_r    <= CNT_ZERO;
      move_r  <= 1'b0;
      fire_r  <= 1'b0;
      held_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      dir_r   <= dir_s;
      rpt_r   <= rpt_s;
      cd_r    <= cd_s;
      move_r  <= move_s;
      fire_r  <= fire_s;
      held_r  <= (state_s == ST_MOVE);
    end
  end

  assign dir  = dir_r;
  assign move = move_r;
  assign held = held_r;
  assign fire = fire_r;

endmodule

// File: rtl/ps2_player_cmd.sv
// Turns the PS/2 receiver's held-key word into tank/train game commands.
// The key word is resynchronised and only accepted once two samples agree.
module ps2_player_cmd
  import ps2_keys_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000,
  parameter int unsigned COOLDOWN     = 12_500_000,
  parameter int unsigned CNT_W        = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] keycode,
  output logic [1:0]  tank_dir,
  output logic        tank_move,
  output logic        tank_held,
  output logic        tank_fire,
  output logic [1:0]  train_dir,
  output logic        train_move,
  output logic        train_held,
  output logic        train_fire,
  output logic        start
);

  logic [15:0] s1_r, s2_r, acc_r, prev_r;
  logic        start_r;
  logic        tank_chg_s, train_chg_s;

  // Two-flop sync, stability filter, previous-value copy and start detect
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_r    <= 16'h0000;
      s2_r    <= 16'h0000;
      acc_r   <= 16'h0000;
      prev_r  <= 16'h0000;
      start_r <= 1'b0;
    end else begin
      s1_r <= keycode;
      s2_r <= s1_r;
      // The receiver updates bytes independently; mixed samples differ here
      if (s2_r == s1_r) begin
        acc_r <= s2_r;
      end else begin
        acc_r <= acc_r;
      end
      prev_r  <= acc_r;
      start_r <= (acc_r[7:0] == KEY_ENTER) && (prev_r[7:0] != KEY_ENTER);
    end
  end

  assign tank_chg_s  = (acc_r[7:0]  != prev_r[7:0]);
  assign train_chg_s = (acc_r[15:8] != prev_r[15:8]);

  ps2_key_ctrl #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE),
    .COOLDOWN     (COOLDOWN),
    .CNT_W        (CNT_W),
    .KEY_UP       (KEY_W),
    .KEY_DOWN     (KEY_S),
    .KEY_LEFT     (KEY_A),
    .KEY_RIGHT    (KEY_D),
    .KEY_FIRE     (KEY_Q)
  ) u_tank (
    .clk     (clk),
    .reset_n (reset_n),
    .key_cur (acc_r[7:0]),
    .key_chg (tank_chg_s),
    .dir     (tank_dir),
    .move    (tank_move),
    .held    (tank_held),
    .fire    (tank_fire)
  );

  ps2_key_ctrl #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE),
    .COOLDOWN     (COOLDOWN),
    .CNT_W        (CNT_W),
    .KEY_UP       (KEY_I),
    .KEY_DOWN     (KEY_K),
    .KEY_LEFT     (KEY_J),
    .KEY_RIGHT    (KEY_L),
    .KEY_FIRE     (KEY_U)
  ) u_train (
    .clk     (clk),
    .reset_n (reset_n),
    .key_cur (acc_r[15:8]),
    .key_chg (train_chg_s),
    .dir     (train_dir),
    .move    (train_move),
    .held    (train_held),
    .fire    (train_fire)
  );

  assign start = start_r;

endmodule

// File: tb/tb_ps2_player_cmd.sv
// Self-checking bench for ps2_player_cmd: expected pulse events are queued
// with their edge number when stimulus is driven and compared by a monitor.
module tb_ps2_player_cmd;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] keycode;
  logic [1:0]  tank_dir, train_dir;
  logic        tank_move, tank_held, tank_fire;
  logic        train_move, train_held, train_fire;
  logic        start;

  ps2_player_cmd #(
    .REPEAT_DELAY (8),
    .REPEAT_RATE  (4),
    .COOLDOWN     (6),
    .CNT_W        (25)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .keycode    (keycode),
    .tank_dir   (tank_dir),
    .tank_move  (tank_move),
    .tank_held  (tank_held),
    .tank_fire  (tank_fire),
    .train_dir  (train_dir),
    .train_move (train_move),
    .train_held (train_held),
    .train_fire (train_fire),
    .start      (start)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] TM = 5'b00001;
  localparam logic [4:0] TF = 5'b00010;
  localparam logic [4:0] RM = 5'b00100;
  localparam logic [4:0] RF = 5'b01000;
  localparam logic [4:0] ST = 5'b10000;
  localparam logic [4:0] NP = 5'b00000;

  typedef struct {
    int         at;
    logic [4:0] pulses;
    logic [1:0] tdir;
    logic [1:0] rdir;
  } exp_t;

  typedef struct {
    logic [15:0] key;
    logic [4:0]  pulses;
    logic [1:0]  tdir;
    logic [1:0]  rdir;
    logic        th;
    logic        rh;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[12];
  int   cyc = 0;
  int   n_tot = 0;
  int   n_pass = 0;
  logic mon_en = 1'b0;
  logic [4:0] mon_p;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tot++;
    if (act === expv) n_pass++;
    else $display("FAIL %s @edge %0d: got %h expected %h", name, cyc, act, expv);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_at(input int rel, input logic [4:0] p, input logic [1:0] td, input logic [1:0] rd);
    exp_t e;
    e.at = cyc + rel;
    e.pulses = p;
    e.tdir = td;
    e.rdir = rd;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: pops the event due at this edge, flags any stray pulse
  always @(negedge clk) begin
    if (mon_en) begin
      mon_p = {start, train_fire, train_move, tank_fire, tank_move};
      if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        mon_e = exp_q.pop_front();
        chk($sformatf("event{pulses,tdir,rdir}@%0d", mon_e.at),
            {25'd0, mon_p, tank_dir, train_dir},
            {25'd0, mon_e.pulses, mon_e.tdir, mon_e.rdir});
      end else if (mon_p != NP) begin
        chk("unexpected pulse", {27'd0, mon_p}, 32'd0);
      end
    end
  end

  initial begin
    tbl[0]  = '{16'h001D, TM,      2'd0, 2'd0, 1'b1, 1'b0};
    tbl[1]  = '{16'h0023, TM,      2'd3, 2'd0, 1'b1, 1'b0};
    tbl[2]  = '{16'h001C, TM,      2'd2, 2'd0, 1'b1, 1'b0};
    tbl[3]  = '{16'h421B, TM | RM, 2'd1, 2'd1, 1'b1, 1'b1};
    tbl[4]  = '{16'h3C15, TF | RF, 2'd1, 2'd1, 1'b0, 1'b0};
    tbl[5]  = '{16'h4B00, RM,      2'd1, 2'd3, 1'b0, 1'b1};
    tbl[6]  = '{16'h3B5A, ST | RM, 2'd1, 2'd2, 1'b0, 1'b1};
    tbl[7]  = '{16'h0000, NP,      2'd1, 2'd2, 1'b0, 1'b0};
    tbl[8]  = '{16'h0015, TF,      2'd1, 2'd2, 1'b0, 1'b0};
    tbl[9]  = '{16'h00FF, NP,      2'd1, 2'd2, 1'b0, 1'b0};
    tbl[10] = '{16'h4300, RM,      2'd1, 2'd0, 1'b0, 1'b1};
    tbl[11] = '{16'h0000, NP,      2'd1, 2'd0, 1'b0, 1'b0};

    reset_n = 1'b0;
    keycode = 16'h0000;
    step(3);
    chk("reset outputs", {20'd0, tank_dir, train_dir, tank_move, tank_held, tank_fire,
                          train_move, train_held, train_fire, start}, 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    step(2);

    // Typematic repeat: first at +4, repeats at +12, +16, +20, stop on release
    keycode = 16'h001D;
    expect_at(4, TM, 2'd0, 2'd0);
    expect_at(12, TM, 2'd0, 2'd0);
    expect_at(16, TM, 2'd0, 2'd0);
    expect_at(20, TM, 2'd0, 2'd0);
    step(10);
    chk("tank_held while W", {31'd0, tank_held}, 32'd1);
    step(8);
    keycode = 16'h0000;
    step(14);
    chk("tank_held after release", {31'd0, tank_held}, 32'd0);

    // Direction switch without release restarts the repeat delay
    keycode = 16'h001D;
    expect_at(4, TM, 2'd0, 2'd0);
    step(6);
    keycode = 16'h0023;
    expect_at(4, TM, 2'd3, 2'd0);
    expect_at(12, TM, 2'd3, 2'd0);
    step(10);
    chk("tank_held after switch", {31'd0, tank_held}, 32'd1);
    keycode = 16'h0000;
    step(8);

    // Fire cooldown: early re-press dropped, late re-press fires, no repeat
    keycode = 16'h0015;
    expect_at(4, TF, 2'd3, 2'd0);
    step(2);
    keycode = 16'h0000;
    step(3);
    keycode = 16'h0015;
    expect_at(4, NP, 2'd3, 2'd0);
    step(3);
    keycode = 16'h0000;
    step(4);
    keycode = 16'h0015;
    expect_at(4, TF, 2'd3, 2'd0);
    step(14);
    chk("tank_held during fire", {31'd0, tank_held}, 32'd0);
    keycode = 16'h0000;
    step(6);

    // One-cycle glitch is filtered; ENTER gives start only
    keycode = 16'h00FF;
    expect_at(4, NP, 2'd3, 2'd0);
    expect_at(5, NP, 2'd3, 2'd0);
    step(1);
    keycode = 16'h0000;
    step(3);
    keycode = 16'h005A;
    expect_at(4, ST, 2'd3, 2'd0);
    step(6);
    chk("tank_held on ENTER", {31'd0, tank_held}, 32'd0);
    keycode = 16'h0000;
    step(6);

    for (int i = 0; i < 12; i++) begin
      keycode = tbl[i].key;
      expect_at(4, tbl[i].pulses, tbl[i].tdir, tbl[i].rdir);
      step(6);
      chk($sformatf("vec%0d held{tank,train}", i), {30'd0, tank_held, train_held},
          {30'd0, tbl[i].th, tbl[i].rh});
    end

    // Reset mid-repeat with a train key still held
    keycode = 16'h4B23;
    expect_at(4, TM | RM, 2'd3, 2'd3);
    step(6);
    keycode = 16'h4300;
    expect_at(4, RM, 2'd3, 2'd0);
    expect_at(12, RM, 2'd3, 2'd0);
    step(13);
    reset_n = 1'b0;
    step(2);
    chk("outputs in reset", {20'd0, tank_dir, train_dir, tank_move, tank_held, tank_fire,
                             train_move, train_held, train_fire, start}, 32'd0);
    reset_n = 1'b1;
    expect_at(4, RM, 2'd0, 2'd0);
    step(8);
    chk("held{tank,train} after reset", {30'd0, tank_held, train_held}, 32'd1);
    keycode = 16'h0000;
    step(6);

    chk("scoreboard drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
